// File: rtl/regs_bank_param.sv
// Parametrised register bank: NREGS x WIDTH registers with valid flags, one
// load/shift write port, synchronous bulk clear and two combinational read ports.
module regs_bank_param #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int AW     = 2,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             Rn,
  input  logic             clear,
  input  logic             we,
  input  logic [1:0]       wmode,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qb,
  output logic             va,
  output logic             vb,
  output logic             sout,
  output logic             valid_all
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            vld_q, vld_d;
  logic                        sout_q, sout_d;
  logic                        wr_en;

  // Rn is folded in so the bypass path also reads zero while in reset.
  assign wr_en = Rn && !clear && we && (wmode != 2'b00) && (32'(waddr) < NREGS);

  always_comb begin
    regs_d = regs_q;
    vld_d  = vld_q;
    sout_d = sout_q;
    if (clear || !Rn) begin
      regs_d = '0;
      vld_d  = '0;
      sout_d = 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (waddr == AW'(i)) begin
          vld_d[i] = 1'b1;
          case (wmode)
            2'b01: regs_d[i] = D;
            2'b10: begin
              regs_d[i] = {regs_q[i][WIDTH-2:0], sin};
              sout_d    = regs_q[i][WIDTH-1];
            end
            2'b11: begin
              regs_d[i] = {sin, regs_q[i][WIDTH-1:1]};
              sout_d    = regs_q[i][0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      regs_q <= '0;
      vld_q  <= '0;
      sout_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      vld_q  <= vld_d;
      sout_q <= sout_d;
    end
  end

  // Bypass reads the next-state view, which equals stored state when idle.
  always_comb begin
    Qa = '0;
    va = 1'b0;
    Qb = '0;
    vb = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr_a == AW'(i)) begin
        Qa = (BYPASS != 0) ? regs_d[i] : regs_q[i];
        va = (BYPASS != 0) ? vld_d[i]  : vld_q[i];
      end
      if (raddr_b == AW'(i)) begin
        Qb = (BYPASS != 0) ? regs_d[i] : regs_q[i];
        vb = (BYPASS != 0) ? vld_d[i]  : vld_q[i];
      end
    end
  end

  assign sout      = sout_q;
  assign valid_all = &vld_q;

endmodule

// File: tb/tb_regs_bank_param.sv
// Bench for regs_bank_param: a 4-register stored-read bank and a 3-register
// bypass bank share one stimulus stream and are compared to an array model.
module tb_regs_bank_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn, clr, we_, si;
  logic [1:0] wm, wa, ra, rb;
  logic [7:0] d;

  logic [1:0][7:0] qa, qb;
  logic [1:0]      va_o, vb_o, sout_o, vall_o;

  regs_bank_param #(.WIDTH(8), .NREGS(4), .AW(2), .BYPASS(0)) u0 (
    .clk(clk), .Rn(rn), .clear(clr), .we(we_), .wmode(wm), .waddr(wa), .D(d),
    .sin(si), .raddr_a(ra), .raddr_b(rb), .Qa(qa[0]), .Qb(qb[0]), .va(va_o[0]),
    .vb(vb_o[0]), .sout(sout_o[0]), .valid_all(vall_o[0]));

  regs_bank_param #(.WIDTH(8), .NREGS(3), .AW(2), .BYPASS(1)) u1 (
    .clk(clk), .Rn(rn), .clear(clr), .we(we_), .wmode(wm), .waddr(wa), .D(d),
    .sin(si), .raddr_a(ra), .raddr_b(rb), .Qa(qa[1]), .Qb(qb[1]), .va(va_o[1]),
    .vb(vb_o[1]), .sout(sout_o[1]), .valid_all(vall_o[1]));

  int checks = 0;
  int errors = 0;

  int   nregs [2] = '{4, 3};
  int   bypass[2] = '{0, 1};
  int   m_reg [2][4];
  bit   m_vld [2][4];
  bit   m_sout[2];
  int   nx_reg[2][4];
  bit   nx_vld[2][4];
  bit   nx_sout[2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void zero_model();
    for (int k = 0; k < 2; k++) begin
      m_sout[k] = 0;
      for (int r = 0; r < 4; r++) begin m_reg[k][r] = 0; m_vld[k][r] = 0; end
    end
  endfunction

  // Next state from the behavioural rules, using the current input values.
  function automatic void model_next();
    for (int k = 0; k < 2; k++) begin
      nx_sout[k] = m_sout[k];
      for (int r = 0; r < 4; r++) begin nx_reg[k][r] = m_reg[k][r]; nx_vld[k][r] = m_vld[k][r]; end
      if (!rn || clr) begin
        nx_sout[k] = 0;
        for (int r = 0; r < 4; r++) begin nx_reg[k][r] = 0; nx_vld[k][r] = 0; end
      end else if (we_ && wm != 0 && int'(wa) < nregs[k]) begin
        int v;
        v = m_reg[k][wa];
        nx_vld[k][wa] = 1;
        if (wm == 1) nx_reg[k][wa] = d;
        else if (wm == 2) begin
          nx_reg[k][wa] = (v * 2 + si) % 256;
          nx_sout[k]    = (v / 128) % 2;
        end else begin
          nx_reg[k][wa] = v / 2 + (si ? 128 : 0);
          nx_sout[k]    = v % 2;
        end
      end
    end
  endfunction

  function automatic void commit();
    for (int k = 0; k < 2; k++) begin
      m_sout[k] = nx_sout[k];
      for (int r = 0; r < 4; r++) begin m_reg[k][r] = nx_reg[k][r]; m_vld[k][r] = nx_vld[k][r]; end
    end
  endfunction

  function automatic void exp_read(int k, int a, output logic [7:0] q, output logic v);
    q = 0; v = 0;
    if (a < nregs[k]) begin
      q = bypass[k] ? 8'(nx_reg[k][a]) : 8'(m_reg[k][a]);
      v = bypass[k] ? nx_vld[k][a] : m_vld[k][a];
    end
  endfunction

  task automatic check_all(string tag);
    logic [7:0] eq;
    logic       ev, eall;
    model_next();
    for (int k = 0; k < 2; k++) begin
      exp_read(k, int'(ra), eq, ev);
      chk($sformatf("%s/Qa%0d", tag, k), 32'(qa[k]), 32'(eq));
      chk($sformatf("%s/va%0d", tag, k), 32'(va_o[k]), 32'(ev));
      exp_read(k, int'(rb), eq, ev);
      chk($sformatf("%s/Qb%0d", tag, k), 32'(qb[k]), 32'(eq));
      chk($sformatf("%s/vb%0d", tag, k), 32'(vb_o[k]), 32'(ev));
      chk($sformatf("%s/sout%0d", tag, k), 32'(sout_o[k]), 32'(m_sout[k]));
      eall = 1;
      for (int r = 0; r < nregs[k]; r++) eall &= m_vld[k][r];
      chk($sformatf("%s/vall%0d", tag, k), 32'(vall_o[k]), 32'(eall));
    end
  endtask

  // Inputs are already driven; check before and after the next rising edge.
  task automatic step(string tag);
    #1;
    if (!rn) zero_model();
    check_all({tag, ".pre"});
    @(posedge clk);
    model_next();
    commit();
    #1;
    check_all({tag, ".post"});
  endtask

  task automatic drv(logic c, logic w, logic [1:0] m, logic [1:0] a, logic [7:0] dd, logic s);
    clr = c; we_ = w; wm = m; wa = a; d = dd; si = s;
  endtask

  initial begin
    zero_model();
    rn = 0; drv(0, 1, 2'b01, 2'd0, 8'hFF, 1); ra = 0; rb = 1;
    // Reset held: clock pulses with a pending load change nothing.
    step("rst0");
    wa = 2; step("rst1");
    chk("rst_qa", 32'(qa[0]), 32'h0);
    rn = 1; drv(0, 0, 2'b00, 2'd0, 8'h00, 0);
    step("idle");

    drv(0, 1, 2'b01, 2'd2, 8'hA5, 0); ra = 2; rb = 2;
    step("ld2");
    drv(0, 0, 2'b00, 2'd0, 8'h00, 0);
    step("rd2");
    chk("ld2_qa", 32'(qa[0]), 32'hA5);
    chk("ld2_vb", 32'(vb_o[0]), 32'h1);
    ra = 0; rb = 3; step("rd03");
    ra = 1; rb = 1; step("rd1");

    drv(0, 1, 2'b01, 2'd1, 8'h81, 0); step("ld1");
    drv(0, 1, 2'b10, 2'd1, 8'h00, 1); step("shl");
    chk("shl_q", 32'(qa[0]), 32'h03);
    chk("shl_sout", 32'(sout_o[0]), 32'h1);
    drv(0, 1, 2'b11, 2'd1, 8'h00, 0); step("shr0");
    chk("shr0_q", 32'(qa[0]), 32'h01);
    drv(0, 1, 2'b11, 2'd1, 8'h00, 1); step("shr1");
    chk("shr1_q", 32'(qa[0]), 32'h80);
    chk("shr1_sout", 32'(sout_o[0]), 32'h1);

    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 2'b01, 2'(i), 8'(8'h10 + i), 0); ra = 2'(i); rb = 2'(3 - i);
      step("ldall");
    end
    chk("vall_set", 32'(vall_o[0]), 32'h1);
    drv(1, 1, 2'b01, 2'd0, 8'h3C, 0); ra = 0; step("clr");
    chk("clr_vall", 32'(vall_o[0]), 32'h0);
    chk("clr_q", 32'(qa[0]), 32'h0);

    drv(0, 1, 2'b01, 2'd2, 8'h77, 0); ra = 2; step("pre5");
    drv(0, 1, 2'b01, 2'd3, 8'h5A, 0); ra = 3; rb = 2; step("byp3");
    drv(0, 1, 2'b01, 2'd2, 8'h5A, 0); ra = 2; step("byp2");

    drv(0, 1, 2'b01, 2'd1, 8'hC3, 0); step("pre6");
    drv(0, 0, 2'b00, 2'd0, 8'h00, 0); ra = 1; rb = 3;
    #3; rn = 0; #1;
    zero_model(); model_next();
    check_all("arst");
    chk("arst_qa", 32'(qa[0]), 32'h0);
    step("arst_hold");
    rn = 1; step("arst_rel");

    for (int i = 0; i < 400; i++) begin
      rn  = ($urandom_range(63) != 0);
      drv(($urandom_range(15) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
          8'($urandom), 1'($urandom));
      ra = 2'($urandom); rb = 2'($urandom);
      step($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_bank_param.md
Name: regs_bank_param

Overview:
Parametrised register bank, successor to the fixed 8-bit clearable register. Holds NREGS registers of WIDTH bits, each with its own valid flag. One write port supports per-register load, shift-left and shift-right modes, plus a synchronous bulk clear. Two read ports with optional write-to-read bypass. Sits between the datapath and the seven-segment/LED display logic as general-purpose storage.

Parameters:
WIDTH, 8, data width of each register (>=2)
NREGS, 4, number of registers (>=2)
AW, 2, address width; must satisfy 2**AW >= NREGS
BYPASS, 0, 1 = read ports forward write data in the same cycle; 0 = read ports show stored value only

Ports:
clk  input  1  rising-edge clock
Rn  input  1  asynchronous active-low reset
clear  input  1  synchronous clear of all registers and valid flags
we  input  1  write enable
wmode  input  2  write mode: 00 hold, 01 load D, 10 shift left, 11 shift right
waddr  input  AW  target register index
D  input  WIDTH  parallel load data
sin  input  1  serial input bit for shift modes
raddr_a  input  AW  read port A index
raddr_b  input  AW  read port B index
Qa  output  WIDTH  read data A
Qb  output  WIDTH  read data B
va  output  1  valid flag of register at raddr_a
vb  output  1  valid flag of register at raddr_b
sout  output  1  registered bit shifted out by the most recent shift operation
valid_all  output  1  1 when every register's valid flag is set

Behaviour:
- Rn low, asynchronously: all registers = 0, all valid flags = 0, sout = 0. Qa/Qb/va/vb/valid_all therefore read 0. This holds regardless of clk, and mid-operation reset discards the pending write.
- Priority on each rising clk edge: clear > write.
- clear=1: all registers = 0, all valid = 0, sout = 0. we is ignored that cycle.
- Write, with we=1 and waddr < NREGS (register r = reg[waddr]):
  - 00: no change.
  - 01: r <= D; valid set.
  - 10: r <= {r[WIDTH-2:0], sin}; sout <= r[WIDTH-1]; valid set.
  - 11: r <= {sin, r[WIDTH-1:1]}; sout <= r[0]; valid set.
- Write with waddr >= NREGS: no register, flag or sout change.
- sout holds its value except on a shift or a clear.
- Reads are combinational from stored state: Qa = reg[raddr_a], va = valid[raddr_a]; same for port B. A read address >= NREGS returns Qx = 0, vx = 0.
- Both ports may address the same register.
- BYPASS=1: when we=1, clear=0, wmode != 00, waddr < NREGS and raddr_x == waddr, Qx shows the next-state value of the register and vx=1 in the same cycle. When clear=1, Qx and vx show 0.
- BYPASS=0: a write is visible on the read ports one cycle after the edge (1-cycle latency).
- valid_all is combinational AND of all NREGS valid flags.
- Registers are fully independent; a write affects only the addressed register.

Test Plan:
1. Rn low, then high; WIDTH=8 and NREGS=4 -> all Qa/Qb=0x00, va=vb=0, valid_all=0, sout=0; while Rn low, pulsing clk with we=1, wmode=01, D=0xFF changes nothing.
2. Load reg2=0xA5 (wmode=01), then raddr_a=2 and raddr_b=2 -> next cycle Qa=Qb=0xA5, va=vb=1; reg0/1/3 remain 0 with valid 0.
3. Load reg1=0x81, then shift-left with sin=1 -> reg1=0x03, sout=1; next shift-right with sin=0 -> reg1=0x01, sout=1; then shift-right with sin=1 -> reg1=0x80, sout=1.
4. Load all four registers -> valid_all=1 after the fourth edge. Assert clear with we=1, wmode=01, D=0x3C on the same edge -> all registers 0, valid_all=0, no load occurs.
5. BYPASS=1: we=1, wmode=01, waddr=3, D=0x5A, raddr_a=3 -> Qa=0x5A, va=1 combinationally before the edge. BYPASS=0 with the same stimulus -> Qa=old value until after the edge.
6. NREGS=3, AW=2: write to waddr=3 -> no state change. raddr_a=3 -> Qa=0, va=0. Assert Rn low mid-sequence after loads -> all state 0 immediately, without a clock edge.
